// File: rtl/pwm_pkg.sv
// pwm_capture shared types and constants.
// FSM states, duty width/scale and a result clamp.
package pwm_pkg;

   typedef enum logic [1:0] {
      WAIT_RISE,
      MEAS_HIGH,
      MEAS_LOW
   } cap_state_t;

   localparam int PCT_W     = 7;
   localparam int PCT_SCALE = 100;

   function automatic logic [PCT_W-1:0] pct_sat(
      input logic [31:0] q
   );
      if (q > 32'(PCT_SCALE))
         pct_sat = PCT_W'(PCT_SCALE);
      else
         pct_sat = q[PCT_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result bundle of pwm_capture.
// master drives the results, slave observes them.
interface pwm_capture_if
   import pwm_pkg::*;
#(
   parameter int CNT_W = 16
);

   logic [CNT_W-1:0] high_time;
   logic [CNT_W-1:0] period;
   logic             meas_valid;
   logic [PCT_W-1:0] duty_pct;
   logic             pct_valid;
   logic             stuck;
   logic             stuck_level;

   modport master (
      output high_time, period, meas_valid,
      output duty_pct, pct_valid,
      output stuck, stuck_level
   );

   modport slave (
      input high_time, period, meas_valid,
      input duty_pct, pct_valid,
      input stuck, stuck_level
   );

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchroniser with registered edge detect.
// level_o is aligned with the rise_o/fall_o pulses.
module pwm_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic pwm_in,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;
   logic rise_q, fall_q;

   // sync chain plus one-cycle edge pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= pwm_in;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         rise_q <= s2_q & ~s3_q;
         fall_q <= ~s2_q & s3_q;
      end
   end

   assign level_o = s3_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: high time, period and duty percent.
// Flags a line with no edges for TIMEOUT cycles.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pwm_in,
   pwm_capture_if.master cap
);

   localparam int DW = CNT_W + PCT_W;
   localparam int KW = $clog2(DW + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [KW-1:0]    K_LAST  = KW'(DW);

   logic lvl, rise, fall;

   pwm_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .pwm_in  (pwm_in),
      .level_o (lvl),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   cap_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_lat_q, high_time_q, period_q;
   logic meas_valid_q, stuck_q, stuck_level_q;
   logic ld_hi, ld_meas, tmo;

   logic busy_q;
   logic [KW-1:0] k_q;
   logic [DW-1:0] quo_q, quo_d;
   logic [CNT_W:0] rem_q, rem_d, rem_sh;
   logic [CNT_W-1:0] dvs_q;
   logic [PCT_W-1:0] duty_q;
   logic pct_valid_q;
   logic ge;

   assign tmo = (cnt_q == TO_VAL) && !rise && !fall;

   // cycle counter: restarts at each rise, saturates
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (rise)
         cnt_d = CNT_W'(1);
      else if (cnt_q == CNT_MAX)
         cnt_d = cnt_q;
   end

   // state and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WAIT_RISE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next state and latch strobes
   always_comb begin
      state_d = state_q;
      ld_hi   = 1'b0;
      ld_meas = 1'b0;
      if (tmo) begin
         state_d = WAIT_RISE;
      end else begin
         unique case (state_q)
            WAIT_RISE:
               if (rise) state_d = MEAS_HIGH;
            MEAS_HIGH:
               if (fall) begin
                  ld_hi   = 1'b1;
                  state_d = MEAS_LOW;
               end
            MEAS_LOW:
               if (rise) begin
                  ld_meas = 1'b1;
                  state_d = MEAS_HIGH;
               end
            default: state_d = WAIT_RISE;
         endcase
      end
   end

   // measurement results and stuck flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_lat_q      <= '0;
         high_time_q   <= '0;
         period_q      <= '0;
         meas_valid_q  <= 1'b0;
         stuck_q       <= 1'b0;
         stuck_level_q <= 1'b0;
      end else begin
         meas_valid_q <= ld_meas;
         if (ld_hi)
            hi_lat_q <= cnt_q;
         if (ld_meas) begin
            high_time_q <= hi_lat_q;
            period_q    <= cnt_q;
         end
         if (tmo) begin
            stuck_q       <= 1'b1;
            stuck_level_q <= lvl;
         end else if (rise || fall) begin
            stuck_q <= 1'b0;
         end
      end
   end

   // one restoring-division step
   always_comb begin
      rem_sh = {rem_q[CNT_W-1:0], quo_q[DW-1]};
      ge     = rem_sh >= {1'b0, dvs_q};
      rem_d  = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
      quo_d  = {quo_q[DW-2:0], ge};
   end

   // divider: restarts on every new measurement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q      <= 1'b0;
         k_q         <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         duty_q      <= '0;
         pct_valid_q <= 1'b0;
      end else begin
         pct_valid_q <= 1'b0;
         if (ld_meas) begin
            busy_q <= 1'b1;
            k_q    <= '0;
            quo_q  <= DW'(hi_lat_q) * DW'(PCT_SCALE);
            rem_q  <= '0;
            dvs_q  <= cnt_q;
         end else if (busy_q) begin
            if (k_q == K_LAST) begin
               busy_q      <= 1'b0;
               pct_valid_q <= 1'b1;
               duty_q      <= pct_sat(32'(quo_q));
            end else begin
               k_q   <= k_q + 1'b1;
               quo_q <= quo_d;
               rem_q <= rem_d;
            end
         end
      end
   end

   assign cap.high_time   = high_time_q;
   assign cap.period      = period_q;
   assign cap.meas_valid  = meas_valid_q;
   assign cap.duty_pct    = duty_q;
   assign cap.pct_valid   = pct_valid_q;
   assign cap.stuck       = stuck_q;
   assign cap.stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture.
// Expected measurements are queued as the waveform is driven.
module tb_pwm_capture;

   localparam int CNT_W = 16;
   localparam int TO    = 200;
   localparam int LAT   = CNT_W + 8;

   typedef struct {
      logic [CNT_W-1:0] h;
      logic [CNT_W-1:0] p;
   } meas_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pwm_in = 1'b0;

   always #5 clk = ~clk;

   pwm_capture_if #(.CNT_W(CNT_W)) cap();

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst    (rst),
      .pwm_in (pwm_in),
      .cap    (cap)
   );

   meas_t exp_q[$];
   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int mv_cyc = 0;
   int mv_seen = 0;
   int pct_seen = 0;
   bit pending = 0;
   logic [6:0] exp_duty = '0;
   bit primed = 0;
   int last_h = 0;
   int last_p = 0;

   function automatic logic [6:0] duty_of(
      input logic [CNT_W-1:0] h,
      input logic [CNT_W-1:0] p
   );
      int d;
      d = int'(h) * 100 / int'(p);
      if (d > 100) d = 100;
      return 7'(d);
   endfunction

   task automatic step();
      meas_t e;
      @(negedge clk);
      cyc++;
      if (!rst) begin
         pending = 0;
      end else begin
         if (cap.meas_valid) begin
            mv_seen++;
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL meas_unexpected: got %0d/%0d, required none",
                        cap.high_time, cap.period);
            end else begin
               e = exp_q.pop_front();
               if (cap.high_time !== e.h || cap.period !== e.p) begin
                  tests_failed++;
                  $display("FAIL meas: got %0d/%0d, required %0d/%0d",
                           cap.high_time, cap.period, e.h, e.p);
               end
               pending  = 1;
               mv_cyc   = cyc;
               exp_duty = duty_of(e.h, e.p);
            end
         end
         if (cap.pct_valid) begin
            pct_seen++;
            tests_run++;
            if (!pending) begin
               tests_failed++;
               $display("FAIL pct_unexpected: got duty %0d, required none",
                        cap.duty_pct);
            end else if (cyc - mv_cyc != LAT ||
                         cap.duty_pct !== exp_duty) begin
               tests_failed++;
               $display("FAIL pct: got lat %0d duty %0d, required %0d %0d",
                        cyc - mv_cyc, cap.duty_pct, LAT, exp_duty);
            end
            pending = 0;
         end else if (pending && cyc - mv_cyc > LAT) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pct_missing: got none, required duty %0d",
                     exp_duty);
            pending = 0;
         end
      end
   endtask

   task automatic pwm_cycles(input int p, input int h, input int n);
      for (int i = 0; i < n; i++) begin
         if (primed)
            exp_q.push_back('{CNT_W'(last_h), CNT_W'(last_p)});
         last_h = h;
         last_p = p;
         primed = 1;
         pwm_in = 1'b1;
         repeat (h) step();
         pwm_in = 1'b0;
         repeat (p - h) step();
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      pwm_in = 1'b0;
      repeat (3) step();
      primed = 0;
      rst = 1'b1;
      repeat (2) step();
   endtask

   task automatic chk_sb_empty(input string name);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL %s: got %0d pending meas, required 0",
                  name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      repeat (3) step();
      tests_run++;
      if ({cap.high_time, cap.period, cap.meas_valid, cap.duty_pct,
           cap.pct_valid, cap.stuck, cap.stuck_level} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %0d/%0d/%0d st %0b, required 0",
                  cap.high_time, cap.period, cap.duty_pct, cap.stuck);
      end
      rst = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_duty_30();
      int mv0, pc0;
      apply_reset();
      mv0 = mv_seen;
      pc0 = pct_seen;
      pwm_cycles(100, 30, 10);
      repeat (30) step();
      tests_run++;
      if (mv_seen - mv0 != 9 || pct_seen - pc0 != 9) begin
         tests_failed++;
         $display("FAIL duty30_counts: got %0d meas %0d pct, required 9 9",
                  mv_seen - mv0, pct_seen - pc0);
      end
      tests_run++;
      if (cap.duty_pct !== 7'd30) begin
         tests_failed++;
         $display("FAIL duty30_value: got %0d, required 30", cap.duty_pct);
      end
      chk_sb_empty("duty30_sb");
   endtask

   task automatic test_switch();
      int mv0;
      apply_reset();
      mv0 = mv_seen;
      pwm_cycles(40, 10, 4);
      pwm_cycles(50, 49, 4);
      repeat (30) step();
      tests_run++;
      if (mv_seen - mv0 != 7) begin
         tests_failed++;
         $display("FAIL switch_count: got %0d, required 7", mv_seen - mv0);
      end
      tests_run++;
      if (cap.high_time !== 16'd49 || cap.period !== 16'd50 ||
          cap.duty_pct !== 7'd98) begin
         tests_failed++;
         $display("FAIL switch_final: got %0d/%0d %0d, required 49/50 98",
                  cap.high_time, cap.period, cap.duty_pct);
      end
      chk_sb_empty("switch_sb");
   endtask

   task automatic test_stuck_high();
      apply_reset();
      pwm_cycles(100, 30, 3);
      exp_q.push_back('{CNT_W'(30), CNT_W'(100)});
      pwm_in = 1'b1;
      repeat (195) step();
      tests_run++;
      if (cap.stuck !== 1'b0) begin
         tests_failed++;
         $display("FAIL stuck_early: got %0b, required 0", cap.stuck);
      end
      repeat (15) step();
      tests_run++;
      if (cap.stuck !== 1'b1 || cap.stuck_level !== 1'b1) begin
         tests_failed++;
         $display("FAIL stuck_high: got %0b lvl %0b, required 1 1",
                  cap.stuck, cap.stuck_level);
      end
      tests_run++;
      if (cap.high_time !== 16'd30 || cap.period !== 16'd100 ||
          cap.duty_pct !== 7'd30) begin
         tests_failed++;
         $display("FAIL stuck_hold: got %0d/%0d %0d, required 30/100 30",
                  cap.high_time, cap.period, cap.duty_pct);
      end
      primed = 0;
      pwm_in = 1'b0;
      repeat (5) step();
      tests_run++;
      if (cap.stuck !== 1'b0) begin
         tests_failed++;
         $display("FAIL stuck_clear: got %0b, required 0", cap.stuck);
      end
      repeat (20) step();
      pwm_cycles(100, 30, 3);
      repeat (30) step();
      chk_sb_empty("stuck_high_sb");
   endtask

   task automatic test_stuck_low();
      int n;
      apply_reset();
      pwm_cycles(100, 30, 3);
      pwm_in = 1'b0;
      n = 0;
      while (cap.stuck !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      tests_run++;
      if (cap.stuck !== 1'b1) begin
         tests_failed++;
         $display("FAIL stuck_low_timeout: got %0b, required 1", cap.stuck);
      end
      tests_run++;
      if (cap.stuck_level !== 1'b0 || cap.duty_pct !== 7'd30 ||
          cap.high_time !== 16'd30) begin
         tests_failed++;
         $display("FAIL stuck_low: got lvl %0b duty %0d ht %0d, required 0 30 30",
                  cap.stuck_level, cap.duty_pct, cap.high_time);
      end
      chk_sb_empty("stuck_low_sb");
   endtask

   task automatic test_short_period();
      int mv0, pc0;
      apply_reset();
      mv0 = mv_seen;
      pc0 = pct_seen;
      pwm_cycles(20, 5, 10);
      tests_run++;
      if (mv_seen - mv0 != 9 || pct_seen - pc0 != 0) begin
         tests_failed++;
         $display("FAIL short_counts: got %0d meas %0d pct, required 9 0",
                  mv_seen - mv0, pct_seen - pc0);
      end
      repeat (40) step();
      chk_sb_empty("short_sb");
   endtask

   task automatic test_reset_mid();
      int mv0;
      apply_reset();
      pwm_cycles(60, 5, 2);
      exp_q.push_back('{CNT_W'(5), CNT_W'(60)});
      pwm_in = 1'b1;
      repeat (5) step();
      pwm_in = 1'b0;
      repeat (10) step();
      chk_sb_empty("mid_sb_before");
      rst = 1'b0;
      #1;
      tests_run++;
      if ({cap.high_time, cap.period, cap.meas_valid, cap.duty_pct,
           cap.pct_valid, cap.stuck, cap.stuck_level} !== '0) begin
         tests_failed++;
         $display("FAIL mid_reset: got %0d/%0d/%0d, required 0",
                  cap.high_time, cap.period, cap.duty_pct);
      end
      repeat (3) step();
      primed = 0;
      rst = 1'b1;
      repeat (2) step();
      mv0 = mv_seen;
      pwm_cycles(60, 5, 1);
      tests_run++;
      if (mv_seen != mv0) begin
         tests_failed++;
         $display("FAIL mid_first_rise: got %0d meas, required 0",
                  mv_seen - mv0);
      end
      pwm_cycles(60, 5, 2);
      repeat (30) step();
      tests_run++;
      if (mv_seen - mv0 != 2) begin
         tests_failed++;
         $display("FAIL mid_resume: got %0d meas, required 2",
                  mv_seen - mv0);
      end
      chk_sb_empty("mid_sb_after");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_duty_30();
      test_switch();
      test_stuck_high();
      test_stuck_low();
      test_short_period();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
